i2c_write_master: RTL and testbench

- Bit-level I2C write engine for the audio codec control path.
- Accepts one 24-bit word {slave address, register address, data} and emits START, 3 bytes with ACK slots, STOP on I2C_SCLK/I2C_SDAT.
- Reports completion and ACK status to the config sequencer upstream, which holds iGO until oEND and then drops it.
- Runs on the system clock with an internal tick enable; no derived clocks.

---
 rtl/i2c_write_master_pkg.sv | 25 ++
 rtl/i2c_write_master_if.sv | 12 +
 rtl/i2c_write_master_tick.sv | 26 ++
 rtl/i2c_write_master.sv | 184 ++++++++++++++++++
 tb/tb_i2c_write_master.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/i2c_write_master_pkg.sv
// Shared types and constants for the I2C write engine: FSM states, bit-phase
// encoding and the fixed tick budget of one transaction.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        BIT,
        ACK,
        STOP,
        DONE
    } state_t;

    localparam logic [1:0] PH_SETUP  = 2'd0;
    localparam logic [1:0] PH_RISE   = 2'd1;
    localparam logic [1:0] PH_SAMPLE = 2'd2;
    localparam logic [1:0] PH_FALL   = 2'd3;

    localparam int START_TICKS = 2;
    localparam int STOP_TICKS  = 3;
    localparam int BYTES       = 3;
    // 2 start ticks + 27 bit slots * 4 ticks + 3 stop ticks
    localparam int TOTAL_TICKS = 113;

endpackage

// File: rtl/i2c_write_master_if.sv
// Command/status handshake between the config sequencer (master) and the
// I2C write engine (slave).
interface i2c_write_master_if;
    logic [23:0] iDATA;
    logic        iGO;
    logic        oEND;
    logic        oACK;
    logic        oBUSY;

    modport master (output iDATA, output iGO, input oEND, input oACK, input oBUSY);
    modport slave  (input iDATA, input iGO, output oEND, output oACK, output oBUSY);
endinterface

// File: rtl/i2c_write_master_tick.sv
// Quarter-bit tick enable: counts 0..DIV-1 while enabled, held at 0 otherwise.
module i2c_tick_gen #(
    parameter int DIV = 4
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic enable,
    output logic tick
);
    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = enable && (cnt == LAST);
endmodule

// File: rtl/i2c_write_master.sv
// Bit-level I2C write engine: START, three bytes each with an ACK slot, STOP.
// All outputs are registered; SDA is open-drain (drive low or release).
//
//  state | meaning
//  IDLE  | bus idle, waiting for iGO
//  START | 2 ticks: SDA low with SCL high, then SCL low
//  BIT   | 4 ticks per data bit, MSB first
//  ACK   | 4 ticks: release SDA, sample slave response on phase 2
//  STOP  | 3 ticks: SDA low, SCL high, SDA released
//  DONE  | oEND high until the sequencer drops iGO
module i2c_write_master
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int I2C_FREQ = 20_000
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    i2c_write_master_if.slave         cmd,
    output logic                      I2C_SCLK,
    inout  wire                       I2C_SDAT
);
    localparam int DIV = CLK_FREQ / (4 * I2C_FREQ);

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [23:0] shift_q, shift_d;
    logic        acc_q, acc_d;
    logic        scl_q, scl_d;
    logic        sda_low_q, sda_low_d;
    logic        end_q, end_d;
    logic        ack_q, ack_d;
    logic        busy_q, busy_d;
    logic        tick;
    logic        sda_in;

    i2c_tick_gen #(.DIV(DIV)) u_tick (
        .iCLK   (iCLK),
        .iRST   (iRST),
        .enable (state_q != IDLE && state_q != DONE),
        .tick   (tick)
    );

    assign sda_in    = I2C_SDAT;
    assign I2C_SDAT  = sda_low_q ? 1'b0 : 1'bz;
    assign I2C_SCLK  = scl_q;
    assign cmd.oEND  = end_q;
    assign cmd.oACK  = ack_q;
    assign cmd.oBUSY = busy_q;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= IDLE;
            phase_q   <= PH_SETUP;
            bit_q     <= 3'd7;
            byte_q    <= 2'd0;
            shift_q   <= '0;
            acc_q     <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
            end_q     <= 1'b0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
            end_q     <= end_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        scl_d     = scl_q;
        sda_low_d = sda_low_q;
        end_d     = end_q;
        ack_d     = ack_q;
        busy_d    = busy_q;

        case (state_q)
            IDLE: begin
                if (cmd.iGO) begin
                    shift_d = cmd.iDATA;
                    acc_d   = 1'b0;
                    ack_d   = 1'b0;
                    busy_d  = 1'b1;
                    phase_d = PH_SETUP;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (phase_q == 2'(START_TICKS - 1)) begin
                        scl_d   = 1'b0;
                        phase_d = PH_SETUP;
                        bit_d   = 3'd7;
                        byte_d  = 2'd0;
                        state_d = BIT;
                    end else begin
                        sda_low_d = 1'b1;
                        phase_d   = phase_q + 2'd1;
                    end
                end
            end
            BIT: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    case (phase_q)
                        PH_SETUP: sda_low_d = ~shift_q[23];
                        PH_RISE:  scl_d = 1'b1;
                        PH_FALL: begin
                            scl_d   = 1'b0;
                            shift_d = {shift_q[22:0], 1'b0};
                            if (bit_q == 3'd0) begin
                                state_d = ACK;
                            end else begin
                                bit_d = bit_q - 3'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ACK: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    case (phase_q)
                        PH_SETUP:  sda_low_d = 1'b0;
                        PH_RISE:   scl_d = 1'b1;
                        PH_SAMPLE: acc_d = acc_q | sda_in;
                        default: begin
                            scl_d = 1'b0;
                            if (byte_q == 2'(BYTES - 1)) begin
                                state_d = STOP;
                            end else begin
                                byte_d  = byte_q + 2'd1;
                                bit_d   = 3'd7;
                                state_d = BIT;
                            end
                        end
                    endcase
                end
            end
            STOP: begin
                if (tick) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == PH_SETUP) begin
                        sda_low_d = 1'b1;
                    end else if (phase_q == 2'(STOP_TICKS - 2)) begin
                        scl_d = 1'b1;
                    end else begin
                        sda_low_d = 1'b0;
                        end_d     = 1'b1;
                        ack_d     = acc_q;
                        busy_d    = 1'b0;
                        phase_d   = PH_SETUP;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (!cmd.iGO) begin
                    end_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_i2c_write_master.sv
// Directed bench for i2c_write_master at DIV=4 with a bus monitor and an
// ACK-capable slave model on the open-drain SDA line.
module tb_i2c_write_master;
    logic iCLK = 1'b0;
    logic iRST;
    always #5 iCLK = ~iCLK;

    i2c_write_master_if bus_if ();

    wire  sda;
    logic scl;
    logic slave_drive = 1'b0;
    logic force_low;
    logic [2:0] nack_mask;

    assign sda = (slave_drive || force_low) ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_write_master #(.CLK_FREQ(320000), .I2C_FREQ(20000)) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .cmd      (bus_if),
        .I2C_SCLK (scl),
        .I2C_SDAT (sda)
    );

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // bus monitor and slave model
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic [7:0] shreg = '0;
    int         bitcnt = 0;
    int         total_starts = 0;
    int         stops = 0;
    logic [7:0] bytes[$];
    logic       acks[$];

    always @(negedge iCLK) begin
        logic cl, cs;
        cl = scl;
        cs = sda;
        if (cl && prev_scl && prev_sda && !cs) begin
            total_starts++;
            stops  = 0;
            bitcnt = 0;
            bytes.delete();
            acks.delete();
            slave_drive = 1'b0;
        end else if (cl && prev_scl && !prev_sda && cs) begin
            stops++;
        end else if (cl && !prev_scl) begin
            if (bitcnt < 8) begin
                shreg = {shreg[6:0], cs};
                bitcnt++;
                if (bitcnt == 8) bytes.push_back(shreg);
            end else begin
                acks.push_back(cs);
                bitcnt = 0;
            end
        end else if (!cl && prev_scl) begin
            if (bitcnt == 8 && bytes.size() <= 3 && !nack_mask[bytes.size() - 1])
                slave_drive = 1'b1;
            else
                slave_drive = 1'b0;
        end
        prev_scl = cl;
        prev_sda = cs;
    end

    task automatic accept(input logic [23:0] data, output int a);
        @(negedge iCLK);
        bus_if.iDATA = data;
        bus_if.iGO   = 1'b1;
        @(posedge iCLK);
        #1;
        a = cyc;
    endtask

    task automatic wait_end(input int a, input string tag);
        int n = 0;
        while (!bus_if.oEND && n < 1000) begin
            @(negedge iCLK);
            n++;
        end
        check({tag, "_end_seen"}, {31'd0, bus_if.oEND}, 32'd1);
        check({tag, "_latency"}, cyc - a, 32'd452);
        #1;
    endtask

    task automatic check_trace(input string tag, input logic [23:0] word, input logic [2:0] exp_acks);
        check({tag, "_nbytes"}, bytes.size(), 32'd3);
        check({tag, "_byte0"}, bytes[0], word[23:16]);
        check({tag, "_byte1"}, bytes[1], word[15:8]);
        check({tag, "_byte2"}, bytes[2], word[7:0]);
        check({tag, "_ackbits"}, {acks[0], acks[1], acks[2]}, exp_acks);
        check({tag, "_stop"}, stops, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int a;
        int snap;
        int bad;
        int n;
        iRST = 1'b1;
        force_low = 1'b0;
        nack_mask = 3'b000;
        bus_if.iGO = 1'b0;
        bus_if.iDATA = '0;
        repeat (3) @(negedge iCLK);
        iRST = 1'b0;
        @(negedge iCLK);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_end", bus_if.oEND, 0);
        check("rst_ack", bus_if.oACK, 0);
        check("rst_busy", bus_if.oBUSY, 0);

        // all bytes ACKed; iDATA scrambled right after acceptance
        accept(24'h34001A, a);
        check("A_busy", bus_if.oBUSY, 1);
        @(negedge iCLK);
        bus_if.iDATA = 24'hFFFFFF;
        wait_end(a, "A");
        check("A_oack", bus_if.oACK, 0);
        check("A_busy_done", bus_if.oBUSY, 0);
        check_trace("A", 24'h34001A, 3'b000);

        // iGO held: no restart
        snap = total_starts;
        repeat (200) @(negedge iCLK);
        check("hold_end", bus_if.oEND, 1);
        check("hold_starts", total_starts, snap);
        check("hold_busy", bus_if.oBUSY, 0);
        bus_if.iGO = 1'b0;
        @(negedge iCLK);
        check("A_end_drop", bus_if.oEND, 0);
        check("A_ack_hold", bus_if.oACK, 0);

        // address byte NACKed, new word
        nack_mask = 3'b001;
        accept(24'h34021A, a);
        wait_end(a, "B");
        check("B_oack", bus_if.oACK, 1);
        check_trace("B", 24'h34021A, 3'b100);
        bus_if.iGO = 1'b0;
        @(negedge iCLK);
        check("B_end_drop", bus_if.oEND, 0);
        check("B_ack_hold", bus_if.oACK, 1);

        // reset in the middle of the second byte
        nack_mask = 3'b000;
        accept(24'h34001A, a);
        repeat (200) @(negedge iCLK);
        #2 iRST = 1'b1;
        #1;
        check("mid_rst_scl", scl, 1);
        check("mid_rst_sda", sda, 1);
        check("mid_rst_busy", bus_if.oBUSY, 0);
        check("mid_rst_end", bus_if.oEND, 0);
        bus_if.iGO = 1'b0;
        @(negedge iCLK);
        iRST = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge iCLK);
            if (scl !== 1'b1 || sda !== 1'b1 || bus_if.oBUSY !== 1'b0) bad++;
        end
        check("post_rst_idle", bad, 0);
        check("post_rst_end", bus_if.oEND, 0);

        // open-drain: with the line pulled low externally, any drive-1 shows up
        force_low = 1'b1;
        accept(24'hFFFFFF, a);
        bad = 0;
        n = 0;
        while (!bus_if.oEND && n < 1000) begin
            @(negedge iCLK);
            if (sda !== 1'b0) bad++;
            n++;
        end
        check("od_end_seen", bus_if.oEND, 1);
        check("od_latency", cyc - a, 452);
        check("od_never_high", bad, 0);
        check("od_oack", bus_if.oACK, 0);
        force_low = 1'b0;
        bus_if.iGO = 1'b0;
        repeat (2) @(negedge iCLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
